fir_stream_ctrl: RTL and testbench

Streaming sequencer for the 16-bit `Hlp` FIR filter. It accepts samples over a valid/ready handshake, buffers them, and drives the filter's `clk_enable`/`filter_in` one sample per enable. It captures `filter_out` into a small output buffer and delivers it downstream with valid/ready backpressure. It also runs a flush sequence of zero samples so the filter tail drains, and it discards the filter's pipeline warm-up outputs.

---
 rtl/fir_stream_ctrl_if.sv | 22 ++
 rtl/fir_stream_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fir_stream_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_stream_ctrl_if.sv
// Valid/ready stream bundle between a sample source/sink and fir_stream_ctrl.
// The master drives input samples and output backpressure; the slave is the controller.
interface fir_stream_ctrl_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fir_stream_ctrl.sv
// Streaming sequencer for the Hlp FIR: input FIFO, paced clk_enable issue,
// warm-up discard, 2-entry output buffer and a zero-sample flush sequence.
//
// state        | meaning
// S_IDLE       | nothing pending
// S_RUN        | FIFO or output path non-empty
// S_FLUSH_WAIT | flush latched, FIFO still draining into the filter
// S_FLUSH      | injecting FLUSH_LEN zero samples
module fir_stream_ctrl #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int FIR_LAT    = 1,
  parameter int FLUSH_LEN  = 32
) (
  input  logic              clk,
  input  logic              reset,
  fir_stream_ctrl_if.slave  strm,
  input  logic              flush,
  output logic              busy,
  output logic              fir_enable,
  output logic [DATA_W-1:0] fir_in,
  input  logic [DATA_W-1:0] fir_out
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WARM_W = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;

  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]       ZERO_LEN  = 16'(FLUSH_LEN);
  localparam logic [WARM_W-1:0] WARM_MAX  = WARM_W'(FIR_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH_WAIT,
    S_FLUSH
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_fifo_cnt;
  logic              r_inflight;
  logic [1:0]        r_out_cnt;
  logic [DATA_W-1:0] r_obuf0;
  logic [DATA_W-1:0] r_obuf1;
  logic [15:0]       r_zcnt;
  logic [WARM_W-1:0] r_warm;

  logic              w_open;
  logic              w_in_ready;
  logic              w_push;
  logic              w_slot;
  logic              w_fifo_src;
  logic              w_zero_src;
  logic              w_issue;
  logic              w_pop_fifo;
  logic              w_keep;
  logic              w_out_pop;
  logic [CNT_W-1:0]  w_fifo_cnt_nxt;
  logic [1:0]        w_out_cnt_nxt;
  logic              w_idle_nxt;
  logic              w_pending;

  assign w_open     = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_in_ready = !reset && w_open && (r_fifo_cnt != FIFO_FULL);
  assign w_push     = strm.in_valid && w_in_ready;

  // Issue is paced purely by registered occupancy so the filter side never
  // sees a combinational path from the stream handshake.
  assign w_slot     = ({1'b0, r_out_cnt} + {2'b00, r_inflight}) < 3'd2;
  assign w_fifo_src = ((r_state == S_RUN) || (r_state == S_FLUSH_WAIT)) &&
                      (r_fifo_cnt != '0);
  assign w_zero_src = (r_state == S_FLUSH) && (r_zcnt < ZERO_LEN);
  assign w_issue    = w_slot && (w_fifo_src || w_zero_src);
  assign w_pop_fifo = w_issue && w_fifo_src;

  assign w_keep     = r_inflight && (r_warm == WARM_MAX);
  assign w_out_pop  = (r_out_cnt != 2'd0) && strm.out_ready;

  assign w_fifo_cnt_nxt = CNT_W'(r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop_fifo));
  assign w_out_cnt_nxt  = 2'(r_out_cnt + 2'(w_keep) - 2'(w_out_pop));
  assign w_idle_nxt     = (w_fifo_cnt_nxt == '0) && !w_issue && (w_out_cnt_nxt == 2'd0);
  assign w_pending      = r_inflight || (r_out_cnt != 2'd0);

  assign strm.in_ready  = w_in_ready;
  assign strm.out_valid = (r_out_cnt != 2'd0);
  assign strm.out_data  = r_obuf0;
  assign fir_enable     = w_issue;
  assign fir_in         = w_pop_fifo ? r_fifo[r_rd_ptr] : '0;
  assign busy           = (r_fifo_cnt != '0) || r_inflight || (r_out_cnt != 2'd0) ||
                          (r_state == S_FLUSH_WAIT) || (r_state == S_FLUSH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_zcnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_state <= S_FLUSH_WAIT;
            r_zcnt  <= '0;
          end else if (w_push) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_FLUSH_WAIT;
            r_zcnt  <= '0;
          end else if (w_idle_nxt) begin
            r_state <= S_IDLE;
          end
        end
        S_FLUSH_WAIT: begin
          if (r_fifo_cnt == '0) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (w_issue) r_zcnt <= r_zcnt + 16'd1;
          if (r_zcnt == ZERO_LEN) r_state <= w_pending ? S_RUN : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= strm.in_data;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_fifo) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_fifo_cnt <= w_fifo_cnt_nxt;
    end
  end

  // The first FIR_LAT-1 captures after reset are pipeline warm-up and are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_warm     <= '0;
      r_out_cnt  <= 2'd0;
      r_obuf0    <= '0;
      r_obuf1    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (r_inflight && (r_warm != WARM_MAX)) r_warm <= r_warm + WARM_W'(1);
      r_out_cnt <= w_out_cnt_nxt;
      if (w_keep && w_out_pop) begin
        if (r_out_cnt == 2'd1) begin
          r_obuf0 <= fir_out;
        end else begin
          r_obuf0 <= r_obuf1;
          r_obuf1 <= fir_out;
        end
      end else if (w_keep) begin
        if (r_out_cnt == 2'd0) r_obuf0 <= fir_out;
        else                   r_obuf1 <= fir_out;
      end else if (w_out_pop) begin
        r_obuf0 <= r_obuf1;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: a FIR_LAT=1 instance driving a 2-tap sum filter
// model, and a FIR_LAT=3 instance driving a 3-stage identity pipeline.
module tb_fir_stream_ctrl;

  localparam int DW   = 16;
  localparam int FLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_a, reset_b;
  logic          flush_a, flush_b;
  logic          busy_a, busy_b;
  logic          en_a, en_b;
  logic [DW-1:0] fin_a, fin_b;
  logic [DW-1:0] fout_a, fout_b;

  fir_stream_ctrl_if #(.DATA_W(DW)) if_a ();
  fir_stream_ctrl_if #(.DATA_W(DW)) if_b ();

  fir_stream_ctrl #(.DATA_W(DW), .FIFO_DEPTH(4), .FIR_LAT(1), .FLUSH_LEN(FLEN)) dut_a (
    .clk(clk), .reset(reset_a), .strm(if_a), .flush(flush_a), .busy(busy_a),
    .fir_enable(en_a), .fir_in(fin_a), .fir_out(fout_a)
  );

  fir_stream_ctrl #(.DATA_W(DW), .FIFO_DEPTH(4), .FIR_LAT(3), .FLUSH_LEN(FLEN)) dut_b (
    .clk(clk), .reset(reset_b), .strm(if_b), .flush(flush_b), .busy(busy_b),
    .fir_enable(en_b), .fir_in(fin_b), .fir_out(fout_b)
  );

  // Filter A: y[k] = x[k] + x[k-1], result valid one enable after the sample.
  logic [DW-1:0] fa_d;
  always @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      fa_d   <= '0;
      fout_a <= '0;
    end else if (en_a) begin
      fa_d   <= fin_a;
      fout_a <= fin_a + fa_d;
    end
  end

  // Filter B: identity through a 3-enable pipeline.
  logic [DW-1:0] fb_p1, fb_p2;
  always @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      fb_p1  <= '0;
      fb_p2  <= '0;
      fout_b <= '0;
    end else if (en_b) begin
      fb_p1  <= fin_b;
      fb_p2  <= fb_p1;
      fout_b <= fb_p2;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] iss_a[$];
  logic [DW-1:0] got_a[$];
  logic [DW-1:0] got_b[$];
  int            outst_a = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_data;

  always @(negedge clk) begin
    if (reset_a) begin
      outst_a    = 0;
      stall_prev = 1'b0;
    end else begin
      if (if_a.in_valid && if_a.in_ready) exp_a.push_back(if_a.in_data);
      if (stall_prev) begin
        chk("stall_valid_hold", if_a.out_valid, 1'b1);
        chk("stall_data_hold", if_a.out_data, stall_data);
      end
      if (en_a) begin
        chk("slot_limit", (outst_a < 2), 1'b1);
        iss_a.push_back(fin_a);
      end else begin
        chk("fir_in_zero_when_idle", fin_a, 0);
      end
      if (if_a.out_valid && if_a.out_ready) got_a.push_back(if_a.out_data);
      outst_a    = outst_a + (en_a ? 1 : 0) - ((if_a.out_valid && if_a.out_ready) ? 1 : 0);
      stall_prev = if_a.out_valid && !if_a.out_ready;
      stall_data = if_a.out_data;
    end
  end

  always @(negedge clk) begin
    if (!reset_b && if_b.out_valid && if_b.out_ready) got_b.push_back(if_b.out_data);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse_reset_a();
    @(posedge clk); #1;
    reset_a = 1'b1;
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.out_ready = 1'b0; flush_a = 1'b0;
    @(negedge clk);
    chk("rstA_in_ready", if_a.in_ready, 1'b0);
    chk("rstA_out_valid", if_a.out_valid, 1'b0);
    chk("rstA_out_data", if_a.out_data, 0);
    chk("rstA_fir_enable", en_a, 1'b0);
    chk("rstA_fir_in", fin_a, 0);
    chk("rstA_busy", busy_a, 1'b0);
    @(posedge clk); #1;
    reset_a = 1'b0;
    exp_a.delete(); iss_a.delete(); got_a.delete();
    @(negedge clk);
    chk("rstA_in_ready_after", if_a.in_ready, 1'b1);
  endtask

  task automatic run_a(input int n, input int rdy_pct, input int vld_pct);
    int sent = 0;
    int cyc  = 0;
    bit acc  = 1'b1;
    while (sent < n && cyc < 20000) begin
      @(posedge clk); #1;
      if (acc) begin
        if ($urandom_range(0, 99) < vld_pct) begin
          if_a.in_valid = 1'b1;
          if_a.in_data  = DW'($urandom);
          acc = 1'b0;
        end else begin
          if_a.in_valid = 1'b0;
        end
      end
      if_a.out_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (if_a.in_valid && if_a.in_ready) begin
        sent++;
        acc = 1'b1;
      end
      cyc++;
    end
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
    if (sent < n) chk("stream_timeout", sent, n);
  endtask

  task automatic drain_a(input int rdy_pct);
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      if_a.out_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      done = !busy_a && !if_a.out_valid;
      cyc++;
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
    if_a.out_ready = 1'b1;
  endtask

  // Reference: issued stream equals accepted samples plus flush zeros in order;
  // each output is the 2-tap sum of consecutive issued samples.
  task automatic compare_a(input string tag);
    logic [DW-1:0] prev = '0;
    logic [DW-1:0] y;
    int m;
    chk({tag, "_issue_count"}, iss_a.size(), exp_a.size());
    chk({tag, "_out_count"}, got_a.size(), exp_a.size());
    m = exp_a.size();
    if (iss_a.size() < m) m = iss_a.size();
    if (got_a.size() < m) m = got_a.size();
    for (int i = 0; i < m; i++) begin
      y    = exp_a[i] + prev;
      prev = exp_a[i];
      chk({tag, "_issued"}, iss_a[i], exp_a[i]);
      chk({tag, "_out_data"}, got_a[i], y);
    end
  endtask

  task automatic send_b(input logic [DW-1:0] x);
    int c = 0;
    @(posedge clk); #1;
    if_b.in_valid = 1'b1;
    if_b.in_data  = x;
    @(negedge clk);
    while (!if_b.in_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) chk("b_send_timeout", 0, 1);
    @(posedge clk); #1;
    if_b.in_valid = 1'b0;
  endtask

  task automatic wait_b_idle();
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      done = !busy_b && !if_b.out_valid;
      cyc++;
    end
    if (!done) chk("b_idle_timeout", 0, 1);
  endtask

  typedef struct {
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          e_in_ready;
    logic          e_en;
    logic [DW-1:0] e_fin;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_busy;
  } vec_t;

  vec_t vecs[5];
  logic [DW-1:0] xb[$];

  initial begin
    // Single sample 0x1234 from idle: enable one cycle after accept, output two edges after.
    vecs[0] = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};

    reset_a = 1'b1; reset_b = 1'b1;
    flush_a = 1'b0; flush_b = 1'b0;
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.out_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstB_in_ready", if_b.in_ready, 1'b0);
    chk("rstB_out_valid", if_b.out_valid, 1'b0);
    chk("rstB_busy", busy_b, 1'b0);
    @(posedge clk); #1;
    reset_b = 1'b0;

    pulse_reset_a();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if_a.in_valid  = vecs[i].in_valid;
      if_a.in_data   = vecs[i].in_data;
      if_a.out_ready = vecs[i].out_ready;
      @(negedge clk);
      chk("vec_in_ready", if_a.in_ready, vecs[i].e_in_ready);
      chk("vec_fir_enable", en_a, vecs[i].e_en);
      chk("vec_fir_in", fin_a, vecs[i].e_fin);
      chk("vec_out_valid", if_a.out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) chk("vec_out_data", if_a.out_data, vecs[i].e_od);
      chk("vec_busy", busy_a, vecs[i].e_busy);
    end
    compare_a("single");

    pulse_reset_a();
    run_a(2000, 100, 100);
    drain_a(100);
    compare_a("stream");

    pulse_reset_a();
    run_a(500, 50, 70);
    drain_a(50);
    compare_a("random");

    pulse_reset_a();
    run_a(6, 0, 100);
    repeat (4) @(negedge clk);
    chk("burst_in_ready_low", if_a.in_ready, 1'b0);
    chk("burst_out_valid", if_a.out_valid, 1'b1);
    chk("burst_head", if_a.out_data, exp_a[0]);
    drain_a(100);
    compare_a("burst");

    pulse_reset_a();
    run_a(10, 100, 100);
    @(posedge clk); #1;
    flush_a = 1'b1;
    for (int k = 0; k < FLEN; k++) exp_a.push_back('0);
    @(posedge clk); #1;
    flush_a = 1'b0;
    if_a.in_valid = 1'b1;
    if_a.in_data  = 16'h7777;
    if_a.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("flush_in_ready_low", if_a.in_ready, 1'b0);
      @(posedge clk); #1;
      flush_a = (k == 9);
    end
    flush_a = 1'b0;
    if_a.in_valid = 1'b0;
    drain_a(100);
    chk("flush_total_outputs", got_a.size(), 10 + FLEN);
    compare_a("flush");

    pulse_reset_a();
    run_a(8, 100, 100);
    pulse_reset_a();
    run_a(1, 100, 100);
    drain_a(100);
    compare_a("after_reset");

    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk); #1;
      reset_b = 1'b1;
      @(negedge clk);
      chk("midrstB_out_valid", if_b.out_valid, 1'b0);
      chk("midrstB_fir_enable", en_b, 1'b0);
      chk("midrstB_busy", busy_b, 1'b0);
      @(posedge clk); #1;
      reset_b = 1'b0;
      got_b.delete();
      xb.delete();
      @(negedge clk);
      chk("midrstB_in_ready", if_b.in_ready, 1'b1);
      for (int k = 0; k < 5; k++) begin
        xb.push_back(DW'($urandom));
        send_b(xb[k]);
      end
      wait_b_idle();
      chk("warmup_out_count", got_b.size(), 3);
      for (int k = 0; k < 3; k++) begin
        if (k < got_b.size()) chk("warmup_out_data", got_b[k], xb[k]);
      end
      if (pass == 0) begin
        for (int k = 0; k < 3; k++) send_b(DW'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
